// File: rtl/mem_arbiter_if.sv
// Fetch, data and unified-memory signals shared by mem_arbiter and its environment.
// The slave modport is the arbiter's view; master is the requesters/memory view.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ack;

  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_funct3, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, m_wstrb, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_funct3, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, m_wstrb, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory bus. Data has priority, but a
// waiting fetch is granted after STARVE_MAX consecutive data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIAct, StDAct} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            m_req_q, m_req_d;
  logic            m_we_q, m_we_d;
  logic [31:0]     m_addr_q, m_addr_d;
  logic [31:0]     m_wdata_q, m_wdata_d;
  logic [3:0]      m_wstrb_q, m_wstrb_d;
  logic [31:0]     i_rdata_q, i_rdata_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic            i_ready_q, i_ready_d;
  logic            d_ready_q, d_ready_d;

  logic [3:0]      st_wstrb;
  logic [31:0]     st_wdata;
  logic            grant_d;

  // Store lane placement: sub-word data is replicated so any lane picks it up.
  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = bus.d_wdata;
    unique case (bus.d_funct3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << bus.d_addr[1:0];
        st_wdata = {4{bus.d_wdata[7:0]}};
      end
      2'b01: begin
        st_wstrb = bus.d_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{bus.d_wdata[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = bus.d_wdata;
      end
    endcase
  end

  assign grant_d = bus.d_req && ((starve_q < StarveMax) || !bus.i_req);

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d  = StDAct;
          m_req_d  = 1'b1;
          m_addr_d = {bus.d_addr[31:2], 2'b00};
          m_we_d   = bus.d_we;
          if (bus.d_we) begin
            m_wstrb_d = st_wstrb;
            m_wdata_d = st_wdata;
          end else begin
            m_wstrb_d = 4'b0000;
            m_wdata_d = 32'h0;
          end
          if (!bus.i_req) begin
            starve_d = '0;
          end else if (starve_q != StarveMax) begin
            starve_d = starve_q + CntW'(1);
          end
        end else if (bus.i_req) begin
          state_d   = StIAct;
          m_req_d   = 1'b1;
          m_addr_d  = {bus.i_addr[31:2], 2'b00};
          m_we_d    = 1'b0;
          m_wstrb_d = 4'b0000;
          m_wdata_d = 32'h0;
          starve_d  = '0;
        end else begin
          starve_d = '0;
        end
      end
      StIAct: begin
        if (bus.m_ack) begin
          state_d   = StIdle;
          m_req_d   = 1'b0;
          i_rdata_d = bus.m_rdata;
          i_ready_d = 1'b1;
        end
      end
      StDAct: begin
        if (bus.m_ack) begin
          state_d   = StIdle;
          m_req_d   = 1'b0;
          d_rdata_d = bus.m_rdata;
          d_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      starve_q  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 32'h0;
      m_wdata_q <= 32'h0;
      m_wstrb_q <= 4'b0000;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_wstrb = m_wstrb_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.i_ready = i_ready_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_ready = d_ready_q;
  assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected memory beats and
// responses; negedge monitors pop and compare whenever the DUT presents them.
module tb_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dcmd_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mexp_t;

  typedef struct {
    logic        chk;
    logic [31:0] rdata;
  } rexp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  mem_arbiter_if tif();

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int mem_delay = 1000;
  logic ack_force = 1'b0;
  logic chk_alt = 1'b0;
  logic prev_m_req = 1'b0;
  int alt_viol = 0;
  int wcnt = 0;

  mexp_t exp_mem[$];
  rexp_t exp_i[$];
  rexp_t exp_d[$];
  int    ready_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Memory model: ack mem_delay cycles after m_req rises, or whenever ack_force is set.
  always @(posedge clk) begin
    #2;
    if (tif.m_req) begin
      tif.m_ack   = ack_force || (wcnt == mem_delay);
      tif.m_rdata = rdata_for(tif.m_addr);
      wcnt        = (wcnt == mem_delay) ? 0 : wcnt + 1;
    end else begin
      tif.m_ack = ack_force;
      wcnt      = 0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (tif.m_req && tif.m_ack) begin
        if (exp_mem.size() == 0) fail_evt("mem_beat");
        else begin
          mexp_t e;
          e = exp_mem.pop_front();
          check("m_addr", tif.m_addr, e.addr);
          check("m_we", 32'(tif.m_we), 32'(e.we));
          check("m_wstrb", 32'(tif.m_wstrb), 32'(e.wstrb));
          if (e.we) check("m_wdata", tif.m_wdata, e.wdata);
        end
      end
      if (tif.i_ready) begin
        if (exp_i.size() == 0) fail_evt("i_ready");
        else begin
          rexp_t r;
          r = exp_i.pop_front();
          if (r.chk) check("i_rdata", tif.i_rdata, r.rdata);
        end
      end
      if (tif.d_ready) begin
        if (exp_d.size() == 0) fail_evt("d_ready");
        else begin
          rexp_t r;
          r = exp_d.pop_front();
          if (r.chk) check("d_rdata", tif.d_rdata, r.rdata);
        end
      end
      if (chk_alt && tif.m_req && prev_m_req) alt_viol++;
    end
    prev_m_req = tif.m_req;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_fetch(input logic [31:0] addrs[$]);
    int t0;
    int n;
    t0 = cyc;
    foreach (addrs[k]) begin
      tif.i_req  = 1'b1;
      tif.i_addr = addrs[k];
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!tif.i_ready && n < 200);
      if (!tif.i_ready) fail_evt("fetch_timeout");
      ready_cyc.push_back(cyc - t0);
    end
    tif.i_req = 1'b0;
  endtask

  task automatic run_data(input dcmd_t cmds[$]);
    int n;
    foreach (cmds[k]) begin
      tif.d_req    = 1'b1;
      tif.d_we     = cmds[k].we;
      tif.d_funct3 = cmds[k].f3;
      tif.d_addr   = cmds[k].addr;
      tif.d_wdata  = cmds[k].wdata;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!tif.d_ready && n < 200);
      if (!tif.d_ready) fail_evt("data_timeout");
    end
    tif.d_req = 1'b0;
  endtask

  task automatic push_store(input logic [31:0] maddr, input logic [31:0] wd, input logic [3:0] ws);
    exp_mem.push_back('{addr: maddr, we: 1'b1, wdata: wd, wstrb: ws});
    exp_d.push_back('{chk: 1'b0, rdata: 32'h0});
  endtask

  task automatic push_read(input logic [31:0] a, input logic is_fetch);
    logic [31:0] al;
    al = {a[31:2], 2'b00};
    exp_mem.push_back('{addr: al, we: 1'b0, wdata: 32'h0, wstrb: 4'b0000});
    if (is_fetch) exp_i.push_back('{chk: 1'b1, rdata: rdata_for(al)});
    else exp_d.push_back('{chk: 1'b1, rdata: rdata_for(al)});
  endtask

  initial begin
    logic [31:0] fa[$];
    dcmd_t       da[$];
    int          n;

    tif.i_req = 1'b0; tif.i_addr = '0;
    tif.d_req = 1'b0; tif.d_we = 1'b0; tif.d_funct3 = '0; tif.d_addr = '0; tif.d_wdata = '0;
    tif.m_rdata = '0; tif.m_ack = 1'b0;

    idle(3);
    reset = 1'b0;
    check("rst_m_req", 32'(tif.m_req), 32'h0);
    check("rst_m_we", 32'(tif.m_we), 32'h0);
    check("rst_i_ready", 32'(tif.i_ready), 32'h0);
    check("rst_d_ready", 32'(tif.d_ready), 32'h0);
    check("rst_busy", 32'(tif.busy), 32'h0);
    check("rst_m_addr", tif.m_addr, 32'h0);
    check("rst_m_wdata", tif.m_wdata, 32'h0);
    check("rst_m_wstrb", 32'(tif.m_wstrb), 32'h0);
    check("rst_i_rdata", tif.i_rdata, 32'h0);
    check("rst_d_rdata", tif.d_rdata, 32'h0);

    // Single fetch, memory acks two cycles after m_req: ready on cycle 4
    mem_delay = 2;
    push_read(32'h100, 1'b1);
    ready_cyc.delete();
    fa = '{32'h100};
    run_fetch(fa);
    check("fetch_latency", 32'(ready_cyc[0]), 32'd4);
    idle(2);

    // Stores of each size plus a data read
    mem_delay = 1;
    push_store(32'h200, 32'hABAB_ABAB, 4'b1000);
    push_store(32'h200, 32'h5A5A_5A5A, 4'b0010);
    push_store(32'h10, 32'hBEEF_BEEF, 4'b1100);
    push_store(32'h20, 32'h5678_5678, 4'b0011);
    push_store(32'h30, 32'hDEAD_BEEF, 4'b1111);
    push_read(32'h44, 1'b0);
    da = '{'{1'b1, 3'b000, 32'h203, 32'h0000_00AB},
           '{1'b1, 3'b000, 32'h201, 32'h1234_565A},
           '{1'b1, 3'b001, 32'h12, 32'h0000_BEEF},
           '{1'b1, 3'b101, 32'h20, 32'h1234_5678},
           '{1'b1, 3'b010, 32'h30, 32'hDEAD_BEEF},
           '{1'b0, 3'b010, 32'h46, 32'hFFFF_FFFF}};
    run_data(da);
    idle(2);

    // Contention with immediate ack: D,D,D,D,I,D,D,D,D,I
    mem_delay = 0;
    for (int k = 0; k < 4; k++) push_read(32'h400 + 32'(4 * k), 1'b0);
    push_read(32'h800, 1'b1);
    for (int k = 4; k < 8; k++) push_read(32'h400 + 32'(4 * k), 1'b0);
    push_read(32'h804, 1'b1);
    fa = '{32'h800, 32'h804};
    da.delete();
    for (int k = 0; k < 8; k++) da.push_back('{1'b0, 3'b010, 32'h400 + 32'(4 * k), 32'h0});
    fork
      run_fetch(fa);
      run_data(da);
    join
    idle(2);

    // Back-to-back fetches with m_ack tied high
    ack_force = 1'b1;
    idle(1);
    chk_alt = 1'b1;
    alt_viol = 0;
    push_read(32'h900, 1'b1);
    push_read(32'h904, 1'b1);
    push_read(32'h908, 1'b1);
    ready_cyc.delete();
    fa = '{32'h900, 32'h904, 32'h908};
    run_fetch(fa);
    check("b2b_ready0", 32'(ready_cyc[0]), 32'd2);
    check("b2b_ready1", 32'(ready_cyc[1]), 32'd4);
    check("b2b_ready2", 32'(ready_cyc[2]), 32'd6);
    idle(3);
    chk_alt = 1'b0;
    check("b2b_m_req_double", 32'(alt_viol), 32'd0);
    ack_force = 1'b0;
    idle(1);

    // i_rdata holds across a data transaction
    mem_delay = 1;
    push_read(32'hA0, 1'b0);
    da = '{'{1'b0, 3'b010, 32'hA0, 32'h0}};
    run_data(da);
    check("i_rdata_hold", tif.i_rdata, rdata_for(32'h908));
    idle(2);

    // Reset in D_ACT before ack, late ack afterwards
    mem_delay = 1000;
    tif.d_req = 1'b1; tif.d_we = 1'b1; tif.d_funct3 = 3'b010;
    tif.d_addr = 32'h500; tif.d_wdata = 32'h1111_2222;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!tif.m_req && n < 20);
    if (!tif.m_req) fail_evt("rst_test_no_m_req");
    reset = 1'b1;
    tif.d_req = 1'b0;
    idle(1);
    reset = 1'b0;
    ack_force = 1'b1;
    idle(1);
    ack_force = 1'b0;
    check("rst_mid_m_req", 32'(tif.m_req), 32'h0);
    check("rst_mid_busy", 32'(tif.busy), 32'h0);
    check("rst_mid_d_ready", 32'(tif.d_ready), 32'h0);
    check("rst_mid_d_rdata", tif.d_rdata, 32'h0);
    idle(4);
    check("rst_mid_idle_busy", 32'(tif.busy), 32'h0);

    check("mem_q_drained", 32'(exp_mem.size()), 32'h0);
    check("i_q_drained", 32'(exp_i.size()), 32'h0);
    check("d_q_drained", 32'(exp_d.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
